channel_deserializer: RTL and testbench

CHANNEL_DESERIALIZER -- requirements
Module: channel_deserializer

---
 rtl/channel_deserializer_pkg.sv | 35 +++
 rtl/channel_deserializer.sv | 110 +++++++++++
 tb/tb_channel_deserializer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/channel_deserializer_pkg.sv
// Frame format shared by channel_serializer and channel_deserializer.
// Marker bytes, field positions and the receive FSM state encoding.
package channel_deserializer_pkg;

    localparam logic [7:0] HDR_MARK = 8'hAA;
    localparam logic [7:0] FTR_MARK = 8'h55;

    localparam int MARK_MSB = 63;
    localparam int MARK_LSB = 56;
    localparam int CH_MSB   = 55;
    localparam int CH_LSB   = 48;
    localparam int CNT_MSB  = 47;
    localparam int CNT_LSB  = 32;
    localparam int TS_MSB   = 31;
    localparam int TS_LSB   = 0;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_FOOTER  = 2'd2
    } rx_state_t;

    function automatic logic [7:0] f_mark(input logic [63:0] w);
        return w[MARK_MSB:MARK_LSB];
    endfunction

    function automatic logic [7:0] f_ch(input logic [63:0] w);
        return w[CH_MSB:CH_LSB];
    endfunction

    function automatic logic [15:0] f_cnt(input logic [63:0] w);
        return w[CNT_MSB:CNT_LSB];
    endfunction

endpackage

// File: rtl/channel_deserializer.sv
// Rebuilds header/payload/footer frames from a FWFT FIFO into AXI-Stream.
// Single FSM with a one-deep registered output stage.
module channel_deserializer
    import channel_deserializer_pkg::*;
#(
    parameter int M_AXIS_TDATA_WIDTH = 64,
    parameter int TX_RX_S_AXIS_WIDTH = 64,
    parameter int ERR_CNT_WIDTH      = 16
) (
    input  logic                          RX_ACLK,
    input  logic                          RX_ARESET,
    input  logic [TX_RX_S_AXIS_WIDTH-1:0] SERIALIZED_DATA,
    input  logic                          DATA_EMPTY,
    output logic                          RD_EN,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    output logic                          M_AXIS_TUSER,
    output logic                          M_AXIS_TLAST,
    output logic [7:0]                    CH_ID,
    output logic                          FTR_ERR,
    output logic [ERR_CNT_WIDTH-1:0]      HDR_ERR_CNT
);

    rx_state_t                     r_state;
    logic [15:0]                   r_cnt;
    logic [M_AXIS_TDATA_WIDTH-1:0] r_tdata;
    logic                          r_tvalid;
    logic                          r_tuser;
    logic                          r_tlast;
    logic [7:0]                    r_ch_id;
    logic                          r_ftr_err;
    logic [ERR_CNT_WIDTH-1:0]      r_err_cnt;

    logic [63:0] w_word;
    logic        w_pop;
    logic        w_is_hdr;

    assign w_word   = 64'(SERIALIZED_DATA);
    assign w_is_hdr = (f_mark(w_word) == HDR_MARK);
    // Pop only when the output slot is free or drains this cycle.
    assign w_pop    = !RX_ARESET && !DATA_EMPTY && (!r_tvalid || M_AXIS_TREADY);

    always_ff @(posedge RX_ACLK or posedge RX_ARESET) begin
        if (RX_ARESET) begin
            r_state   <= ST_HUNT;
            r_cnt     <= '0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_tuser   <= 1'b0;
            r_tlast   <= 1'b0;
            r_ch_id   <= '0;
            r_ftr_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_ftr_err <= 1'b0;
            if (r_tvalid && M_AXIS_TREADY) begin
                r_tvalid <= 1'b0;
            end
            if (w_pop) begin
                unique case (r_state)
                    ST_HUNT: begin
                        if (w_is_hdr) begin
                            r_tdata  <= M_AXIS_TDATA_WIDTH'(w_word);
                            r_tvalid <= 1'b1;
                            r_tuser  <= 1'b1;
                            r_tlast  <= 1'b0;
                            r_ch_id  <= f_ch(w_word);
                            r_cnt    <= f_cnt(w_word);
                            r_state  <= (f_cnt(w_word) != 16'd0) ? ST_PAYLOAD : ST_FOOTER;
                        end else if (r_err_cnt != '1) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                    end
                    ST_PAYLOAD: begin
                        r_tdata  <= M_AXIS_TDATA_WIDTH'(w_word);
                        r_tvalid <= 1'b1;
                        r_tuser  <= 1'b0;
                        r_tlast  <= 1'b0;
                        r_cnt    <= r_cnt - 16'd1;
                        if (r_cnt == 16'd1) begin
                            r_state <= ST_FOOTER;
                        end
                    end
                    ST_FOOTER: begin
                        r_tdata   <= M_AXIS_TDATA_WIDTH'(w_word);
                        r_tvalid  <= 1'b1;
                        r_tuser   <= 1'b0;
                        r_tlast   <= 1'b1;
                        r_ftr_err <= (f_mark(w_word) != FTR_MARK);
                        r_state   <= ST_HUNT;
                    end
                    default: begin
                        r_state <= ST_HUNT;
                    end
                endcase
            end
        end
    end

    assign RD_EN         = w_pop;
    assign M_AXIS_TDATA  = r_tdata;
    assign M_AXIS_TVALID = r_tvalid;
    assign M_AXIS_TUSER  = r_tuser;
    assign M_AXIS_TLAST  = r_tlast;
    assign CH_ID         = r_ch_id;
    assign FTR_ERR       = r_ftr_err;
    assign HDR_ERR_CNT   = r_err_cnt;

endmodule

// File: tb/tb_channel_deserializer.sv
// Directed bench for channel_deserializer with a small FWFT FIFO model.
// Inputs change 1ns after the rising edge; beats are sampled on the falling edge.
module tb_channel_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ser_data;
    logic        data_empty;
    logic        rd_en;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;
    logic [7:0]  ch_id;
    logic        ftr_err;
    logic [15:0] err_cnt;

    int errors = 0;
    int checks = 0;
    int ftr_pulses;
    logic [63:0] q[$];
    logic [63:0] got_d[$];
    logic        got_u[$];
    logic        got_l[$];
    logic [63:0] exp_d[$];

    always #5 clk = ~clk;

    channel_deserializer #(
        .M_AXIS_TDATA_WIDTH(64),
        .TX_RX_S_AXIS_WIDTH(64),
        .ERR_CNT_WIDTH(16)
    ) dut (
        .RX_ACLK(clk),
        .RX_ARESET(rst),
        .SERIALIZED_DATA(ser_data),
        .DATA_EMPTY(data_empty),
        .RD_EN(rd_en),
        .M_AXIS_TDATA(tdata),
        .M_AXIS_TVALID(tvalid),
        .M_AXIS_TREADY(tready),
        .M_AXIS_TUSER(tuser),
        .M_AXIS_TLAST(tlast),
        .CH_ID(ch_id),
        .FTR_ERR(ftr_err),
        .HDR_ERR_CNT(err_cnt)
    );

    function automatic logic [63:0] hdr(input logic [7:0] ch, input logic [15:0] n,
                                        input logic [31:0] ts);
        return {8'hAA, ch, n, ts};
    endfunction

    task automatic upd();
        data_empty = (q.size() == 0);
        ser_data   = (q.size() == 0) ? 64'h0 : q[0];
    endtask

    task automatic push(input logic [63:0] w);
        q.push_back(w);
        exp_d.push_back(w);
        upd();
    endtask

    task automatic push_junk(input logic [63:0] w);
        q.push_back(w);
        upd();
    endtask

    task automatic clear_log();
        got_d.delete();
        got_u.delete();
        got_l.delete();
        exp_d.delete();
        ftr_pulses = 0;
    endtask

    task automatic step();
        logic pop_now;
        @(negedge clk);
        pop_now = rd_en;
        if (tvalid && tready) begin
            got_d.push_back(tdata);
            got_u.push_back(tuser);
            got_l.push_back(tlast);
        end
        if (ftr_err) ftr_pulses++;
        @(posedge clk);
        #1;
        if (pop_now && q.size() > 0) q.delete(0);
        upd();
    endtask

    task automatic run_until(input int n, output int used);
        used = 0;
        while (got_d.size() < n && used < 200) begin
            step();
            used++;
        end
        checks++;
        if (got_d.size() < n) begin
            errors++;
            $display("FAIL beat_timeout: got %0d beats, need %0d", got_d.size(), n);
        end
    endtask

    task automatic do_reset();
        q.delete();
        upd();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tready = 1'b1;
        q.delete();
        push_junk(hdr(8'h01, 16'd1, 32'h0));
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tvalid, tuser, tlast, ftr_err, rd_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {tvalid, tuser, tlast, ftr_err, rd_en});
        end
        checks++;
        if (tdata !== 64'h0 || ch_id !== 8'h0 || err_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_regs: tdata=%h ch=%h cnt=%0d want zeros", tdata, ch_id, err_cnt);
        end
        q.delete();
        upd();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int used;
        clear_log();
        tready = 1'b1;
        push(hdr(8'h05, 16'd3, 32'h1234_5678));
        push(64'h1111_0000_0000_0001);
        push(64'hAA00_0000_0000_0002);
        push(64'h3333_0000_0000_0003);
        push(64'h5500_0000_0000_00FF);
        step();
        checks++;
        if (tvalid !== 1'b1 || tdata !== 64'hAA05_0003_1234_5678 || tuser !== 1'b1) begin
            errors++;
            $display("FAIL latency: tvalid=%b tdata=%h tuser=%b want 1 aa05000312345678 1",
                     tvalid, tdata, tuser);
        end
        run_until(5, used);
        checks++;
        if (used + 1 !== 6) begin
            errors++;
            $display("FAIL throughput: %0d cycles, want 6", used + 1);
        end
        for (int i = 0; i < 5 && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_u[i] !== (i == 0) || got_l[i] !== (i == 4)) begin
                errors++;
                $display("FAIL basic_beat%0d: %h u%b l%b want %h u%b l%b", i, got_d[i],
                         got_u[i], got_l[i], exp_d[i], i == 0, i == 4);
            end
        end
        checks++;
        if (ch_id !== 8'h05 || ftr_pulses !== 0) begin
            errors++;
            $display("FAIL basic_ch: ch=%h ftr=%0d want 05 0", ch_id, ftr_pulses);
        end
    endtask

    task automatic test_hunt();
        int used;
        clear_log();
        push_junk(64'h1234_0000_0000_0000);
        push_junk(64'hAB00_0000_0000_0001);
        push(hdr(8'h21, 16'd1, 32'hCAFE));
        push(64'h0000_0000_0000_00AA);
        push(64'h5500_0000_0000_0000);
        run_until(3, used);
        repeat (2) step();
        checks++;
        if (err_cnt !== 16'd2 || got_d.size() !== 3) begin
            errors++;
            $display("FAIL hunt_drop: errcnt=%0d beats=%0d want 2 3", err_cnt, got_d.size());
        end
        for (int i = 0; i < 3 && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_u[i] !== (i == 0) || got_l[i] !== (i == 2)) begin
                errors++;
                $display("FAIL hunt_beat%0d: %h want %h", i, got_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_bad_footer();
        int used;
        clear_log();
        push(hdr(8'h22, 16'd0, 32'h0));
        push(64'h1200_0000_0000_0007);
        run_until(2, used);
        repeat (2) step();
        checks++;
        if (got_d.size() !== 2 || got_l[1] !== 1'b1 || got_u[0] !== 1'b1 || got_d[1] !== exp_d[1]) begin
            errors++;
            $display("FAIL badftr_beats: n=%0d last=%b want 2 1", got_d.size(), got_l[1]);
        end
        checks++;
        if (ftr_pulses !== 1) begin
            errors++;
            $display("FAIL badftr_pulse: %0d pulses want 1", ftr_pulses);
        end
        push_junk(64'h0100_0000_0000_0000);
        repeat (3) step();
        checks++;
        if (err_cnt !== 16'd3 || got_d.size() !== 2) begin
            errors++;
            $display("FAIL badftr_hunt: errcnt=%0d beats=%0d want 3 2", err_cnt, got_d.size());
        end
    endtask

    task automatic test_stall();
        int used;
        logic [63:0] held;
        clear_log();
        tready = 1'b1;
        push(hdr(8'h07, 16'd3, 32'h77));
        push(64'h0000_0000_0000_0A01);
        push(64'h0000_0000_0000_0A02);
        push(64'h0000_0000_0000_0A03);
        push(64'h5500_0000_0000_0A04);
        step();
        step();
        tready = 1'b0;
        held = tdata;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (rd_en !== 1'b0 || tvalid !== 1'b1 || tdata !== held) begin
                errors++;
                $display("FAIL stall_hold%0d: rd=%b v=%b tdata=%h want 0 1 %h",
                         i, rd_en, tvalid, tdata, held);
            end
        end
        tready = 1'b1;
        run_until(5, used);
        repeat (2) step();
        checks++;
        if (got_d.size() !== 5) begin
            errors++;
            $display("FAIL stall_count: %0d beats want 5", got_d.size());
        end
        for (int i = 0; i < 5 && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL stall_beat%0d: %h want %h", i, got_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_empty();
        int used;
        clear_log();
        push(hdr(8'h0E, 16'd2, 32'hE));
        push(64'h0000_0000_0000_0E01);
        run_until(2, used);
        repeat (10) step();
        checks++;
        if (tvalid !== 1'b0 || got_d.size() !== 2) begin
            errors++;
            $display("FAIL empty_idle: v=%b beats=%0d want 0 2", tvalid, got_d.size());
        end
        push(64'hAA00_0000_0000_0E02);
        push(64'h5500_0000_0000_0E03);
        run_until(4, used);
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_u[i] !== (i == 0) || got_l[i] !== (i == 3)) begin
                errors++;
                $display("FAIL empty_beat%0d: %h u%b l%b want %h", i, got_d[i],
                         got_u[i], got_l[i], exp_d[i]);
            end
        end
        checks++;
        if (ftr_pulses !== 0) begin
            errors++;
            $display("FAIL empty_ftr: %0d pulses want 0", ftr_pulses);
        end
    endtask

    task automatic test_reset_mid();
        int used;
        clear_log();
        push(hdr(8'h09, 16'd4, 32'h9));
        push(64'h0000_0000_0000_0901);
        run_until(2, used);
        q.delete();
        upd();
        rst = 1'b1;
        #1;
        checks++;
        if ({tvalid, tuser, tlast, rd_en} !== 4'b0 || tdata !== 64'h0 || ch_id !== 8'h0) begin
            errors++;
            $display("FAIL midrst_zero: v%b u%b l%b rd%b tdata=%h ch=%h want zeros",
                     tvalid, tuser, tlast, rd_en, tdata, ch_id);
        end
        step();
        rst = 1'b0;
        step();
        clear_log();
        push(hdr(8'h33, 16'd1, 32'h3));
        push(64'h0000_0000_0000_3301);
        push(64'h5500_0000_0000_3302);
        run_until(3, used);
        for (int i = 0; i < 3 && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_u[i] !== (i == 0) || got_l[i] !== (i == 2)) begin
                errors++;
                $display("FAIL midrst_beat%0d: %h u%b l%b want %h", i, got_d[i],
                         got_u[i], got_l[i], exp_d[i]);
            end
        end
        checks++;
        if (ch_id !== 8'h33 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrst_ch: ch=%h errcnt=%0d want 33 0", ch_id, err_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        tready = 1'b0;
        ftr_pulses = 0;
        upd();
        test_reset();
        test_basic();
        test_hunt();
        test_bad_footer();
        test_stall();
        test_empty();
        test_reset_mid();
        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
